// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the control unit: opcodes, FSM states, datapath mux codes
// and the next-pc selector.
package unidade_controle_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_ADDI  = 4'h3;
  localparam logic [3:0] OP_SUBI  = 4'h4;
  localparam logic [3:0] OP_LI    = 4'h5;
  localparam logic [3:0] OP_LOAD  = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h7;
  localparam logic [3:0] OP_JMPF  = 4'h8;
  localparam logic [3:0] OP_JMPB  = 4'h9;
  localparam logic [3:0] OP_JGT   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Write-back source (controle_a)
  localparam logic [1:0] SRC_IMM = 2'b00;
  localparam logic [1:0] SRC_ULA = 2'b01;
  localparam logic [1:0] SRC_MEM = 2'b10;

  // ALU B operand (controle_input_ula)
  localparam logic [1:0] ULA_B_REG  = 2'b00;
  localparam logic [1:0] ULA_B_IMM  = 2'b01;
  localparam logic [1:0] ULA_B_ZERO = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS1   = 2'd0,
    PC_PLUS2   = 2'd1,
    PC_ADD_IMM = 2'd2,
    PC_SUB_IMM = 2'd3
  } pc_sel_t;

  // Unassigned opcodes collapse to NOP so the FSM only ever sees known encodings.
  function automatic logic [3:0] legal_op(input logic [3:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_LI,
      OP_LOAD, OP_STORE, OP_JMPF, OP_JMPB, OP_JGT, OP_HALT: legal_op = op;
      default: legal_op = OP_NOP;
    endcase
  endfunction

  function automatic logic writes_reg(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_LI, OP_LOAD: writes_reg = 1'b1;
      default: writes_reg = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Control-unit bus: instruction/data memory handshakes, ALU flags and datapath controls.
interface unidade_controle_if;
  logic [15:0] imem_data;
  logic        imem_ready;
  logic        imem_req;
  logic [7:0]  pc;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        zero;
  logic        neg;
  logic [1:0]  controle_a;
  logic        controle_b;
  logic [1:0]  controle_input_ula;
  logic        controle_gt;
  logic        controle_jumps;
  logic        controle_halt;
  logic        reg_write;
  logic        alu_sub;

  modport master (
    input  imem_data, imem_ready, dmem_ready, zero, neg,
    output imem_req, pc, dmem_req, dmem_we, controle_a, controle_b,
           controle_input_ula, controle_gt, controle_jumps, controle_halt,
           reg_write, alu_sub
  );

  modport slave (
    output imem_data, imem_ready, dmem_ready, zero, neg,
    input  imem_req, pc, dmem_req, dmem_we, controle_a, controle_b,
           controle_input_ula, controle_gt, controle_jumps, controle_halt,
           reg_write, alu_sub
  );
endinterface

// File: rtl/pc_next.sv
// Next program-counter arithmetic; all results wrap modulo 256.
module pc_next
  import unidade_controle_pkg::*;
(
  input  logic [7:0] pc_i,
  input  logic [3:0] imm_i,
  input  pc_sel_t    sel_i,
  output logic [7:0] pc_o
);

  always_comb begin
    case (sel_i)
      PC_PLUS1:   pc_o = pc_i + 8'd1;
      PC_PLUS2:   pc_o = pc_i + 8'd2;
      PC_ADD_IMM: pc_o = pc_i + {4'b0000, imm_i};
      PC_SUB_IMM: pc_o = pc_i - {4'b0000, imm_i};
      default:    pc_o = pc_i + 8'd1;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB/HALTED sequencer driving the
// datapath muxes and memory handshakes; every output is registered.
module unidade_controle
  import unidade_controle_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  unidade_controle_if.master bus
);

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;  // {opcode, imm}; rd/rs are consumed by the datapath directly
  logic [7:0] pc_q, pc_d, pc_next_s;
  pc_sel_t    pc_sel_s;
  logic       pc_load_s;
  logic [3:0] op_s;

  logic       imem_req_q, imem_req_d;
  logic       dmem_req_q, dmem_req_d;
  logic       dmem_we_q, dmem_we_d;
  logic       reg_write_q, reg_write_d;
  logic       jumps_q, jumps_d;
  logic       halt_q, halt_d;
  logic [1:0] ctrl_a_q, ctrl_a_d;
  logic       ctrl_b_q, ctrl_b_d;
  logic [1:0] ula_b_q, ula_b_d;
  logic       gt_q, gt_d;
  logic       alu_sub_q, alu_sub_d;

  assign op_s = legal_op(ir_q[7:4]);

  pc_next u_pc_next (
    .pc_i  (pc_q),
    .imm_i (ir_q[3:0]),
    .sel_i (pc_sel_s),
    .pc_o  (pc_next_s)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_sel_s  = PC_PLUS1;
    pc_load_s = 1'b0;
    ctrl_a_d  = ctrl_a_q;
    ctrl_b_d  = ctrl_b_q;
    ula_b_d   = ula_b_q;
    gt_d      = gt_q;
    alu_sub_d = alu_sub_q;

    case (state_q)
      ST_FETCH: begin
        if (bus.imem_ready) begin
          ir_d    = {bus.imem_data[15:12], bus.imem_data[3:0]};
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        ctrl_a_d  = SRC_IMM;
        ula_b_d   = ULA_B_REG;
        ctrl_b_d  = writes_reg(op_s);
        gt_d      = 1'b0;
        alu_sub_d = 1'b0;
        case (op_s)
          OP_ADD:  ctrl_a_d = SRC_ULA;
          OP_SUB:  begin ctrl_a_d = SRC_ULA; alu_sub_d = 1'b1; end
          OP_ADDI: begin ctrl_a_d = SRC_ULA; ula_b_d = ULA_B_IMM; end
          OP_SUBI: begin ctrl_a_d = SRC_ULA; ula_b_d = ULA_B_IMM; alu_sub_d = 1'b1; end
          OP_LOAD: begin ctrl_a_d = SRC_MEM; ula_b_d = ULA_B_ZERO; end
          OP_STORE: ula_b_d = ULA_B_ZERO;
          OP_JMPB: gt_d = 1'b1;
          OP_JGT:  alu_sub_d = 1'b1;  // compare rd against rs
          default: ctrl_a_d = SRC_IMM;
        endcase
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (op_s)
          OP_LOAD, OP_STORE: state_d = ST_MEM;
          OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_LI: state_d = ST_WB;
          OP_HALT: state_d = ST_HALTED;
          OP_JMPF: begin pc_sel_s = PC_ADD_IMM; pc_load_s = 1'b1; state_d = ST_FETCH; end
          OP_JMPB: begin pc_sel_s = PC_SUB_IMM; pc_load_s = 1'b1; state_d = ST_FETCH; end
          OP_JGT: begin
            pc_sel_s  = (!bus.zero && !bus.neg) ? PC_PLUS2 : PC_PLUS1;
            pc_load_s = 1'b1;
            state_d   = ST_FETCH;
          end
          default: begin pc_load_s = 1'b1; state_d = ST_FETCH; end
        endcase
      end
      ST_MEM: begin
        if (!bus.dmem_ready) begin
          state_d = ST_MEM;
        end else if (op_s == OP_LOAD) begin
          state_d = ST_WB;
        end else begin
          pc_load_s = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_WB: begin
        pc_load_s = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH;
    endcase

    pc_d = pc_load_s ? pc_next_s : pc_q;

    // Status outputs follow the state being entered so they are valid throughout it.
    imem_req_d  = (state_d == ST_FETCH);
    dmem_req_d  = (state_d == ST_MEM);
    dmem_we_d   = (state_d == ST_MEM) && (op_s == OP_STORE);
    reg_write_d = (state_d == ST_WB);
    jumps_d     = (state_d == ST_EXEC) && (op_s == OP_JGT);
    halt_d      = (state_d == ST_HALTED);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FETCH;
      ir_q        <= 8'h00;
      pc_q        <= 8'h00;
      imem_req_q  <= 1'b1;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      reg_write_q <= 1'b0;
      jumps_q     <= 1'b0;
      halt_q      <= 1'b0;
      ctrl_a_q    <= 2'b00;
      ctrl_b_q    <= 1'b0;
      ula_b_q     <= 2'b00;
      gt_q        <= 1'b0;
      alu_sub_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      imem_req_q  <= imem_req_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      reg_write_q <= reg_write_d;
      jumps_q     <= jumps_d;
      halt_q      <= halt_d;
      ctrl_a_q    <= ctrl_a_d;
      ctrl_b_q    <= ctrl_b_d;
      ula_b_q     <= ula_b_d;
      gt_q        <= gt_d;
      alu_sub_q   <= alu_sub_d;
    end
  end

  assign bus.imem_req           = imem_req_q;
  assign bus.pc                 = pc_q;
  assign bus.dmem_req           = dmem_req_q;
  assign bus.dmem_we            = dmem_we_q;
  assign bus.reg_write          = reg_write_q;
  assign bus.controle_jumps     = jumps_q;
  assign bus.controle_halt      = halt_q;
  assign bus.controle_a         = ctrl_a_q;
  assign bus.controle_b         = ctrl_b_q;
  assign bus.controle_input_ula = ula_b_q;
  assign bus.controle_gt        = gt_q;
  assign bus.alu_sub            = alu_sub_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed scenarios plus a random
// instruction stream checked against an instruction-level reference model.
module tb_unidade_controle;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   total   = 0;
  int   bad     = 0;
  logic [7:0] model_pc = 8'h00;

  unidade_controle_if bus ();

  unidade_controle dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int lat; int rw_cnt; int rw_cyc; int dm_cnt; int jc;
    logic we; logic halted; logic tmo;
    logic [1:0] ca; logic [1:0] iu; logic cb; logic gt; logic sub;
  } obs_t;

  typedef struct {
    int lat; int rw; int dm; int jc;
    logic we; logic halt; logic [7:0] pc;
  } exp_t;

  // Instruction-level model: cycles, pc effect and strobes of one instruction.
  task automatic ref_model(input logic [15:0] instr, input int mw, input logic z,
                           input logic n, input logic [7:0] pc_in, output exp_t e);
    int p; int imm; logic [3:0] op;
    op = instr[15:12]; imm = int'(instr[3:0]); p = int'(pc_in);
    e = '{default: 0};
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin e.lat = 4; e.rw = 1; p = p + 1; end
      4'h6: begin e.lat = 4 + mw; e.rw = 1; e.dm = mw; p = p + 1; end
      4'h7: begin e.lat = 3 + mw; e.dm = mw; e.we = 1'b1; p = p + 1; end
      4'h8: begin e.lat = 3; p = p + imm; end
      4'h9: begin e.lat = 3; p = p - imm; end
      4'hA: begin e.lat = 3; e.jc = 1; p = p + ((!z && !n) ? 2 : 1); end
      4'hF: begin e.lat = 3; e.halt = 1'b1; end
      default: begin e.lat = 3; p = p + 1; end
    endcase
    e.pc = 8'((p + 256) % 256);
  endtask

  task automatic do_reset();
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.zero = 1'b0; bus.neg = 1'b0;
    bus.imem_data = 16'h0000;
    reset_n = 1'b0;
    #3;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    model_pc = 8'h00;
  endtask

  // Drives one instruction from FETCH until the DUT is back in FETCH (or halted).
  task automatic run_instr(input logic [15:0] instr, input int fw, input int mw,
                           input logic z, input logic n, output obs_t o);
    int c; logic done;
    o = '{default: 0};
    done = 1'b0; c = 1;
    bus.zero = z; bus.neg = n; bus.dmem_ready = 1'b0;
    for (int i = 0; i < fw; i++) begin
      bus.imem_ready = 1'b0; bus.imem_data = 16'($urandom);
      @(posedge clock); #1; c++;
    end
    bus.imem_data = instr; bus.imem_ready = 1'b1;
    @(posedge clock); #1; c++;
    for (int t = 0; t < 64 && !done; t++) begin
      if (bus.imem_req === 1'b1 || bus.controle_halt === 1'b1) begin
        done = 1'b1; o.halted = bus.controle_halt; o.lat = c - 1 - fw;
      end else begin
        if (bus.reg_write === 1'b1) begin o.rw_cnt++; o.rw_cyc = c - fw; end
        if (bus.dmem_req === 1'b1) begin o.dm_cnt++; o.we = o.we | bus.dmem_we; end
        if (bus.controle_jumps === 1'b1) o.jc++;
        o.ca = bus.controle_a; o.iu = bus.controle_input_ula; o.cb = bus.controle_b;
        o.gt = bus.controle_gt; o.sub = bus.alu_sub;
        if (bus.dmem_req === 1'b1) bus.dmem_ready = (o.dm_cnt == mw);
        else bus.dmem_ready = 1'($urandom_range(0, 1));
        bus.imem_ready = 1'($urandom_range(0, 1));
        bus.imem_data  = 16'($urandom);
        @(posedge clock); #1; c++;
      end
    end
    o.tmo = !done;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.zero = 1'b0; bus.neg = 1'b0;
    bus.imem_data = 16'h0000;
    #1 reset_n = 1'b0;
    #2;
    total++;
    if (bus.pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", bus.pc); end
    total++;
    if ({bus.dmem_req, bus.dmem_we, bus.reg_write, bus.controle_halt, bus.controle_jumps,
         bus.controle_a, bus.controle_b, bus.controle_input_ula, bus.controle_gt,
         bus.alu_sub} !== 12'd0) begin
      bad++; $display("FAIL reset_outputs got nonzero exp=all zero");
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    total++;
    if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL reset_imem_req got=%b exp=1", bus.imem_req); end
    model_pc = 8'h00;
  endtask

  task automatic test_addi();
    obs_t o;
    do_reset();
    run_instr(16'h3125, 0, 1, 1'b0, 1'b0, o);
    total++; if (o.lat !== 4) begin bad++; $display("FAIL addi_latency got=%0d exp=4", o.lat); end
    total++; if (o.rw_cnt !== 1 || o.rw_cyc !== 4) begin
      bad++; $display("FAIL addi_reg_write got cnt=%0d cyc=%0d exp cnt=1 cyc=4", o.rw_cnt, o.rw_cyc);
    end
    total++; if (o.iu !== 2'b01 || o.ca !== 2'b01 || o.sub !== 1'b0) begin
      bad++; $display("FAIL addi_controls got iu=%b a=%b sub=%b exp iu=01 a=01 sub=0", o.iu, o.ca, o.sub);
    end
    total++; if (bus.pc !== 8'h01) begin bad++; $display("FAIL addi_pc got=%h exp=01", bus.pc); end
    model_pc = 8'h01;
  endtask

  task automatic test_load_wait();
    obs_t o;
    do_reset();
    run_instr(16'h6210, 0, 3, 1'b0, 1'b0, o);
    total++; if (o.dm_cnt !== 3 || o.we !== 1'b0) begin
      bad++; $display("FAIL load_dmem got req_cycles=%0d we=%b exp 3/0", o.dm_cnt, o.we);
    end
    total++; if (o.ca !== 2'b10) begin bad++; $display("FAIL load_src got=%b exp=10", o.ca); end
    total++; if (o.rw_cnt !== 1 || o.rw_cyc !== 7 || o.lat !== 7) begin
      bad++; $display("FAIL load_wb got cnt=%0d cyc=%0d lat=%0d exp 1/7/7", o.rw_cnt, o.rw_cyc, o.lat);
    end
    total++; if (bus.pc !== 8'h01) begin bad++; $display("FAIL load_pc got=%h exp=01", bus.pc); end
    model_pc = 8'h01;
  endtask

  task automatic test_jgt();
    obs_t o;
    logic [1:0] flags [3];
    logic [7:0] exp_pc [3];
    flags[0] = 2'b00; exp_pc[0] = 8'h12;
    flags[1] = 2'b10; exp_pc[1] = 8'h11;
    flags[2] = 2'b01; exp_pc[2] = 8'h11;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      run_instr(16'h800F, 0, 1, 1'b0, 1'b0, o);
      run_instr(16'h0000, 0, 1, 1'b0, 1'b0, o);
      total++; if (bus.pc !== 8'h10) begin bad++; $display("FAIL jgt_setup_pc got=%h exp=10", bus.pc); end
      run_instr(16'hA123, 0, 1, flags[k][1], flags[k][0], o);
      total++; if (bus.pc !== exp_pc[k]) begin
        bad++; $display("FAIL jgt_pc zn=%b got=%h exp=%h", flags[k], bus.pc, exp_pc[k]);
      end
      total++; if (o.jc !== 1 || o.lat !== 3 || bus.controle_jumps !== 1'b0) begin
        bad++; $display("FAIL jgt_jumps got cycles=%0d lat=%0d after=%b exp 1/3/0", o.jc, o.lat, bus.controle_jumps);
      end
    end
    model_pc = 8'h11;
  endtask

  task automatic test_jumps();
    obs_t o;
    do_reset();
    run_instr(16'h0000, 0, 1, 1'b0, 1'b0, o);
    run_instr(16'h0000, 1, 1, 1'b0, 1'b0, o);
    run_instr(16'h9005, 0, 1, 1'b0, 1'b0, o);
    total++; if (bus.pc !== 8'hFD || o.gt !== 1'b1) begin
      bad++; $display("FAIL jmpb got pc=%h gt=%b exp pc=fd gt=1", bus.pc, o.gt);
    end
    run_instr(16'h0000, 0, 1, 1'b0, 1'b0, o);
    run_instr(16'h8003, 0, 1, 1'b0, 1'b0, o);
    total++; if (bus.pc !== 8'h01 || o.gt !== 1'b0) begin
      bad++; $display("FAIL jmpf_wrap got pc=%h gt=%b exp pc=01 gt=0", bus.pc, o.gt);
    end
    model_pc = 8'h01;
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic [15:0] instr; logic [3:0] op; int fw; int mw; logic z; logic n;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 14));
      instr = {op, 12'($urandom)};
      fw = $urandom_range(0, 2); mw = $urandom_range(1, 3);
      z = 1'($urandom_range(0, 1)); n = 1'($urandom_range(0, 1));
      ref_model(instr, mw, z, n, model_pc, e);
      run_instr(instr, fw, mw, z, n, o);
      total++;
      if (o.tmo || o.lat !== e.lat || bus.pc !== e.pc || o.rw_cnt !== e.rw || o.dm_cnt !== e.dm ||
          o.we !== e.we || o.jc !== e.jc) begin
        bad++;
        $display("FAIL rand_instr %h got lat=%0d pc=%h rw=%0d dm=%0d we=%b jc=%0d exp lat=%0d pc=%h rw=%0d dm=%0d we=%b jc=%0d",
                 instr, o.lat, bus.pc, o.rw_cnt, o.dm_cnt, o.we, o.jc, e.lat, e.pc, e.rw, e.dm, e.we, e.jc);
      end
      case (op)
        4'h1, 4'h2: begin
          total++;
          if (o.iu !== 2'b00 || o.ca !== 2'b01 || o.cb !== 1'b1 || o.sub !== (op == 4'h2)) begin
            bad++; $display("FAIL rand_alu_ctrl op=%h got iu=%b a=%b b=%b sub=%b", op, o.iu, o.ca, o.cb, o.sub);
          end
        end
        4'h3, 4'h4: begin
          total++;
          if (o.iu !== 2'b01 || o.ca !== 2'b01 || o.cb !== 1'b1 || o.sub !== (op == 4'h4)) begin
            bad++; $display("FAIL rand_imm_ctrl op=%h got iu=%b a=%b b=%b sub=%b", op, o.iu, o.ca, o.cb, o.sub);
          end
        end
        4'h5: begin
          total++;
          if (o.ca !== 2'b00 || o.cb !== 1'b1) begin bad++; $display("FAIL rand_li_ctrl got a=%b b=%b exp 00/1", o.ca, o.cb); end
        end
        4'h6: begin
          total++;
          if (o.ca !== 2'b10 || o.cb !== 1'b1) begin bad++; $display("FAIL rand_load_ctrl got a=%b b=%b exp 10/1", o.ca, o.cb); end
        end
        4'h7: begin
          total++;
          if (o.cb !== 1'b0) begin bad++; $display("FAIL rand_store_ctrl got b=%b exp 0", o.cb); end
        end
        4'h8, 4'h9: begin
          total++;
          if (o.gt !== (op == 4'h9)) begin bad++; $display("FAIL rand_jmp_gt op=%h got gt=%b", op, o.gt); end
        end
        default: begin end
      endcase
      model_pc = e.pc;
    end
  endtask

  task automatic test_halt();
    obs_t o;
    do_reset();
    for (int k = 0; k < 3; k++) run_instr(16'h0000, 0, 1, 1'b0, 1'b0, o);
    run_instr(16'hF000, 0, 1, 1'b0, 1'b0, o);
    total++; if (o.halted !== 1'b1 || o.lat !== 3 || bus.pc !== 8'h03) begin
      bad++; $display("FAIL halt_entry got halt=%b lat=%0d pc=%h exp 1/3/03", o.halted, o.lat, bus.pc);
    end
    for (int k = 0; k < 20; k++) begin
      bus.imem_ready = k[0]; bus.dmem_ready = 1'($urandom_range(0, 1)); bus.imem_data = 16'($urandom);
      @(posedge clock); #1;
      total++;
      if (bus.pc !== 8'h03 || bus.controle_halt !== 1'b1 || bus.imem_req !== 1'b0 || bus.reg_write !== 1'b0) begin
        bad++; $display("FAIL halt_frozen cyc=%0d got pc=%h halt=%b req=%b exp 03/1/0", k, bus.pc, bus.controle_halt, bus.imem_req);
      end
    end
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++; if (bus.pc !== 8'h00 || bus.controle_halt !== 1'b0 || bus.imem_req !== 1'b1) begin
      bad++; $display("FAIL halt_reset got pc=%h halt=%b req=%b exp 00/0/1", bus.pc, bus.controle_halt, bus.imem_req);
    end
    @(posedge clock); #1 reset_n = 1'b1;
    model_pc = 8'h00;
    run_instr(16'h0000, 0, 1, 1'b0, 1'b0, o);
    total++; if (bus.pc !== 8'h01 || o.lat !== 3) begin
      bad++; $display("FAIL halt_restart got pc=%h lat=%0d exp 01/3", bus.pc, o.lat);
    end
    model_pc = 8'h01;
  endtask

  task automatic test_reset_in_store();
    obs_t o;
    do_reset();
    run_instr(16'h0000, 0, 1, 1'b0, 1'b0, o);
    run_instr(16'h0000, 0, 1, 1'b0, 1'b0, o);
    total++; if (bus.pc !== 8'h02) begin bad++; $display("FAIL store_setup_pc got=%h exp=02", bus.pc); end
    bus.imem_data = 16'h7120; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
    @(posedge clock); #1; bus.imem_ready = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    total++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1) begin
      bad++; $display("FAIL store_mem got req=%b we=%b exp 1/1", bus.dmem_req, bus.dmem_we);
    end
    @(posedge clock); #1;
    #2 reset_n = 1'b0;
    #1;
    total++; if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.reg_write !== 1'b0 || bus.pc !== 8'h00) begin
      bad++; $display("FAIL store_abort got req=%b we=%b rw=%b pc=%h exp 0/0/0/00", bus.dmem_req, bus.dmem_we, bus.reg_write, bus.pc);
    end
    bus.dmem_ready = 1'b1;
    @(posedge clock); #1 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      total++;
      if (bus.reg_write !== 1'b0 || bus.dmem_req !== 1'b0 || bus.pc !== 8'h00) begin
        bad++; $display("FAIL store_after_reset cyc=%0d got rw=%b req=%b pc=%h", k, bus.reg_write, bus.dmem_req, bus.pc);
      end
    end
    bus.dmem_ready = 1'b0;
    model_pc = 8'h00;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_jgt();
    test_jumps();
    test_random();
    test_halt();
    test_reset_in_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 clock  input  1  single system clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 imem_data  input  16  instruction word: opcode[15:12], rd[11:8], rs[7:4], imm[3:0].
REQ-004 imem_ready  input  1  instruction memory has valid imem_data this cycle.
REQ-005 imem_req  output  1  fetch request; address is pc.
REQ-006 pc  output  8  program counter.
REQ-007 dmem_req  output  1  data memory access request.
REQ-008 dmem_we  output  1  1 = store, 0 = load; valid while dmem_req=1.
REQ-009 dmem_ready  input  1  data memory completed access this cycle.
REQ-010 zero, neg  input  1 each  ALU flags from the current EXEC cycle.
REQ-011 controle_a  output  2  write-back source: 00 imm, 01 ULA, 10 memory.
REQ-012 controle_b  output  1  1 = result to register bank, 0 = to memory.
REQ-013 controle_input_ula  output  2  ALU B operand: 00 register, 01 imm, 10 zero.
REQ-014 controle_gt  output  1  1 = pc - imm, 0 = pc + imm (relative jump).
REQ-015 controle_jumps  output  1  conditional-jump instruction in EXEC.
REQ-016 controle_halt  output  1  processor halted.
REQ-017 reg_write  output  1  register bank write strobe, one cycle per write-back.
REQ-018 alu_sub  output  1  1 = ALU subtracts, 0 = adds.

Function
REQ-019 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALTED.
REQ-020 FETCH SHALL hold imem_req=1 until imem_ready=1, latch imem_data into the instruction register, then go to DECODE.
REQ-021 DECODE SHALL last exactly one cycle and set all control outputs from the opcode.
REQ-022 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 ADDI, 4 SUBI, 5 LI, 6 LOAD, 7 STORE, 8 JMPF, 9 JMPB, A JGT, F HALT; all others SHALL execute as NOP.
REQ-023 ADD/SUB: input_ula=00, controle_a=01; ADDI/SUBI: input_ula=01, controle_a=01; LI: controle_a=00; LOAD: controle_a=10; STORE: controle_b=0.
REQ-024 EXEC SHALL last one cycle; LOAD/STORE go to MEM, register-writing ops go to WB, all others return to FETCH.
REQ-025 MEM SHALL hold dmem_req=1 (dmem_we per opcode) until dmem_ready=1; LOAD then goes to WB, STORE goes to FETCH.
REQ-026 WB SHALL pulse reg_write for exactly one cycle, then go to FETCH.
REQ-027 Non-jump instructions SHALL update pc to pc+1 on leaving the instruction's last state.
REQ-028 JMPF/JMPB SHALL update pc to pc+imm / pc-imm (imm zero-extended, modulo 256); controle_gt=0 / 1.
REQ-029 JGT SHALL assert controle_jumps in EXEC and SHALL set pc to pc+2 when zero=0 and neg=0, otherwise pc+1.
REQ-030 HALT SHALL enter HALTED, assert controle_halt, and freeze pc; only reset_n exits HALTED.
REQ-031 pc wrap-around: 8'hFF+1 SHALL give 8'h00, with no flag raised.
REQ-032 Zero-wait latency: ALU/LI 4 cycles, JMP/JGT/NOP 3 cycles, LOAD 5 cycles, STORE 4 cycles.
REQ-033 imem_ready/dmem_ready asserted outside their wait states SHALL be ignored.

Reset
REQ-034 reset_n=0 SHALL immediately force state=FETCH, pc=0, instruction register=0, and every output to 0 except imem_req.
REQ-035 imem_req SHALL be 1 from the first clock edge after reset_n deasserts; reset during MEM or WB SHALL abort without a write strobe.

Structure
REQ-036 Opcode constants, state encoding, and controle_a/input_ula codes SHALL live in a shared package used with the datapath muxes.
REQ-037 The next-pc arithmetic (+1, +2, ±imm) SHALL be one sub-module, pc_next.

Verification
REQ-038 Reset, then ADDI (16'h3125) with imem_ready=1 -> input_ula=01, controle_a=01, one reg_write pulse in cycle 4, pc=1.
REQ-039 LOAD with dmem_ready delayed 3 cycles -> dmem_req held 3 cycles, dmem_we=0, controle_a=10, reg_write after ready, pc+1.
REQ-040 JGT at pc=8'h10: zero=0, neg=0 -> pc=8'h12; zero=1 -> pc=8'h11; controle_jumps=1 only in EXEC.
REQ-041 JMPB imm=5 at pc=8'h02 -> pc=8'hFD, controle_gt=1; JMPF imm=3 at pc=8'hFE -> pc=8'h01.
REQ-042 HALT -> controle_halt=1, pc frozen for 20 cycles with imem_ready toggling; reset_n low -> pc=0, state FETCH.
REQ-043 reset_n asserted during a STORE's MEM wait -> dmem_req drops asynchronously, no reg_write, pc=0.
